// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types and constants for the ASCON AD absorption controller
package ascon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_PAD    = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  localparam logic [63:0] AD_PAD_WORD = 64'h8000_0000_0000_0000;
  localparam logic [63:0] DSEP_MASK   = 64'h0000_0000_0000_0001;

  // Keep the leading nbytes of data (byte 0 is the MSB) and append 0x80 right after them.
  function automatic logic [63:0] pad_partial(input logic [63:0] data,
                                              input logic [2:0]  nbytes);
    logic [5:0] sh;
    sh = {nbytes, 3'b000};
    return (data & ~({64{1'b1}} >> sh)) | (AD_PAD_WORD >> sh);
  endfunction

endpackage

// File: rtl/ad_absorb_ctrl_p6.sv
// rtl/ad_absorb_ctrl_p6.sv - combinational six-round ASCON permutation (rounds 6..11 of p12)
module ad_absorb_ctrl_p6 (
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic [63:0] y0_o,
  output logic [63:0] y1_o,
  output logic [63:0] y2_o,
  output logic [63:0] y3_o,
  output logic [63:0] y4_o
);

  localparam logic [7:0] RC [6] = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] round_f(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    {a0, a1, a2, a3, a4} = s;
    a2 = a2 ^ {56'd0, c};
    // Bit-sliced 5-bit S-box
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    // Linear diffusion layer
    a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    return {a0, a1, a2, a3, a4};
  endfunction

  logic [319:0] st;

  always_comb begin
    st = {x0_i, x1_i, x2_i, x3_i, x4_i};
    for (int r = 0; r < 6; r++) begin
      st = round_f(st, RC[r]);
    end
  end

  assign {y0_o, y1_o, y2_o, y3_o, y4_o} = st;

endmodule

// File: rtl/ad_absorb_ctrl.sv
// rtl/ad_absorb_ctrl.sv - ASCON associated-data absorption FSM with padding and domain separation
module ad_absorb_ctrl
  import ascon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             has_ad,
  input  logic [63:0]      x0,
  input  logic [63:0]      x1,
  input  logic [63:0]      x2,
  input  logic [63:0]      x3,
  input  logic [63:0]      x4,
  input  logic             ad_valid,
  input  logic [63:0]      ad_data,
  input  logic [3:0]       ad_bytes,
  input  logic             ad_last,
  output logic             ad_ready,
  output logic             busy,
  output logic             done,
  output logic [63:0]      y0,
  output logic [63:0]      y1,
  output logic [63:0]      y2,
  output logic [63:0]      y3,
  output logic [63:0]      y4,
  output logic [CNT_W-1:0] blk_cnt
);

  state_e           state_q, state_d;
  logic [63:0]      s_q [5];
  logic [63:0]      s_d [5];
  logic [63:0]      y_q [5];
  logic [63:0]      y_d [5];
  logic [63:0]      p_in [5];
  logic [63:0]      p_out [5];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             perm_en;
  logic             partial_last;
  logic [63:0]      absorb_word;

  // ad_bytes[3] set means 8..15, all of which count as a full word.
  assign partial_last = ad_last && !ad_bytes[3];
  assign absorb_word  = partial_last ? pad_partial(ad_data, ad_bytes[2:0]) : ad_data;

  always_comb begin
    p_in[0] = (state_q == ST_PAD) ? (s_q[0] ^ AD_PAD_WORD) : (s_q[0] ^ absorb_word);
    p_in[1] = s_q[1];
    p_in[2] = s_q[2];
    p_in[3] = s_q[3];
    p_in[4] = s_q[4];
  end

  ad_absorb_ctrl_p6 u_p6 (
    .x0_i (p_in[0]),
    .x1_i (p_in[1]),
    .x2_i (p_in[2]),
    .x3_i (p_in[3]),
    .x4_i (p_in[4]),
    .y0_o (p_out[0]),
    .y1_o (p_out[1]),
    .y2_o (p_out[2]),
    .y3_o (p_out[3]),
    .y4_o (p_out[4])
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    perm_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d[0]  = x0;
          s_d[1]  = x1;
          s_d[2]  = x2;
          s_d[3]  = x3;
          s_d[4]  = x4;
          cnt_d   = '0;
          state_d = has_ad ? ST_ABSORB : ST_FIN;
        end
      end
      ST_ABSORB: begin
        if (ad_valid) begin
          perm_en = 1'b1;
          if (ad_last) begin
            state_d = ad_bytes[3] ? ST_PAD : ST_FIN;
          end
        end
      end
      ST_PAD: begin
        perm_en = 1'b1;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        y_d     = s_q;
        y_d[4]  = s_q[4] ^ DSEP_MASK;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (perm_en) begin
      s_d   = p_out;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < 5; i++) begin
        s_q[i] <= '0;
        y_q[i] <= '0;
      end
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ad_ready = (state_q == ST_ABSORB);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign y0       = y_q[0];
  assign y1       = y_q[1];
  assign y2       = y_q[2];
  assign y3       = y_q[3];
  assign y4       = y_q[4];
  assign blk_cnt  = cnt_q;

endmodule

// File: tb/tb_ad_absorb_ctrl.sv
// tb/tb_ad_absorb_ctrl.sv - directed self-checking bench for ad_absorb_ctrl
module tb_ad_absorb_ctrl;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        has_ad = 1'b0;
  logic [63:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic        ad_valid = 1'b0;
  logic [63:0] ad_data = '0;
  logic [3:0]  ad_bytes = '0;
  logic        ad_last = 1'b0;

  logic        ad_ready, busy, done;
  logic [63:0] y0, y1, y2, y3, y4;
  logic [15:0] blk_cnt;
  logic        s_ready, s_busy, s_done;
  logic [63:0] s_y0, s_y1, s_y2, s_y3, s_y4;
  logic [1:0]  s_cnt;

  ad_absorb_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .has_ad(has_ad),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .ad_valid(ad_valid), .ad_data(ad_data), .ad_bytes(ad_bytes), .ad_last(ad_last),
    .ad_ready(ad_ready), .busy(busy), .done(done),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .blk_cnt(blk_cnt));

  ad_absorb_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .has_ad(has_ad),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
    .ad_valid(ad_valid), .ad_data(ad_data), .ad_bytes(ad_bytes), .ad_last(ad_last),
    .ad_ready(s_ready), .busy(s_busy), .done(s_done),
    .y0(s_y0), .y1(s_y1), .y2(s_y2), .y3(s_y3), .y4(s_y4), .blk_cnt(s_cnt));

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] x_in [5];
  logic [63:0] ad_w [8];
  logic [63:0] exp_y [5];
  int          exp_cnt;
  logic [63:0] obs_y [5];
  logic [63:0] obs_sy [5];
  int          obs_cnt, obs_lat;
  logic [1:0]  obs_cnt2;
  bit          obs_rdy_seen, obs_pad_rdy, obs_timeout, obs_busy1;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Table-driven reference of the six-round permutation
  function automatic logic [319:0] p6_ref(input logic [319:0] st);
    logic [63:0] a [5];
    logic [63:0] b [5];
    logic [4:0]  col, o;
    logic [7:0]  rc;
    for (int k = 0; k < 5; k++) a[k] = st[319 - 64*k -: 64];
    for (int r = 6; r < 12; r++) begin
      rc = {4'(15 - r), 4'(r)};
      a[2] = a[2] ^ {56'd0, rc};
      for (int bi = 0; bi < 64; bi++) begin
        col = {a[0][bi], a[1][bi], a[2][bi], a[3][bi], a[4][bi]};
        o = SBOX[col];
        for (int k = 0; k < 5; k++) b[k][bi] = o[4-k];
      end
      a[0] = b[0] ^ rotr(b[0], 19) ^ rotr(b[0], 28);
      a[1] = b[1] ^ rotr(b[1], 61) ^ rotr(b[1], 39);
      a[2] = b[2] ^ rotr(b[2], 1)  ^ rotr(b[2], 6);
      a[3] = b[3] ^ rotr(b[3], 10) ^ rotr(b[3], 17);
      a[4] = b[4] ^ rotr(b[4], 7)  ^ rotr(b[4], 41);
    end
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  task automatic ref_run(input bit ha, input int n, input int lb);
    logic [319:0] st;
    logic [63:0]  blk;
    st = {x_in[0], x_in[1], x_in[2], x_in[3], x_in[4]};
    exp_cnt = 0;
    if (ha) begin
      for (int i = 0; i < n; i++) begin
        blk = ad_w[i];
        if (i == n - 1 && lb < 8) begin
          for (int bt = 0; bt < 8; bt++)
            blk[63 - 8*bt -: 8] = (bt < lb) ? ad_w[i][63 - 8*bt -: 8] : ((bt == lb) ? 8'h80 : 8'h00);
        end
        st[319:256] = st[319:256] ^ blk;
        st = p6_ref(st);
        exp_cnt++;
        if (i == n - 1 && lb >= 8) begin
          st[319:256] = st[319:256] ^ 64'h8000_0000_0000_0000;
          st = p6_ref(st);
          exp_cnt++;
        end
      end
    end
    for (int k = 0; k < 5; k++) exp_y[k] = st[319 - 64*k -: 64];
    exp_y[4] = exp_y[4] ^ 64'h1;
  endtask

  // Drives one run; returns at the falling edge where done is seen.
  task automatic do_run(input bit ha, input int n, input int lb, input int gap,
                        input bit busy_start, input bit chain);
    int cyc;
    int guard;
    obs_rdy_seen = 1'b0;
    obs_pad_rdy  = 1'b0;
    obs_timeout  = 1'b0;
    @(negedge clk);
    start = 1'b1; has_ad = ha;
    x0 = x_in[0]; x1 = x_in[1]; x2 = x_in[2]; x3 = x_in[3]; x4 = x_in[4];
    cyc = 0;
    @(negedge clk);
    cyc = 1;
    obs_busy1 = busy;
    if (busy_start) begin
      x0 = ~x_in[0]; x1 = ~x_in[1]; x2 = ~x_in[2]; x3 = ~x_in[3]; x4 = ~x_in[4];
    end else begin
      start = 1'b0;
    end
    if (ha) begin
      for (int i = 0; i < n; i++) begin
        repeat (gap) begin
          ad_valid = 1'b0;
          @(negedge clk);
          cyc++;
        end
        ad_valid = 1'b1;
        ad_data  = ad_w[i];
        ad_last  = (i == n - 1);
        ad_bytes = (i == n - 1) ? 4'(lb) : 4'd3;
        guard = 0;
        while (!ad_ready && guard < 10) begin
          @(negedge clk);
          cyc++;
          guard++;
        end
        if (!ad_ready) obs_timeout = 1'b1;
        @(negedge clk);
        cyc++;
      end
      ad_valid = 1'b0; ad_last = 1'b0; ad_data = '0; ad_bytes = '0;
      obs_pad_rdy = ad_ready;
    end
    while (!done && cyc < 300) begin
      obs_rdy_seen = obs_rdy_seen | ad_ready;
      @(negedge clk);
      cyc++;
    end
    if (!done) obs_timeout = 1'b1;
    obs_lat  = cyc;
    obs_cnt  = int'(blk_cnt);
    obs_cnt2 = s_cnt;
    obs_y[0] = y0; obs_y[1] = y1; obs_y[2] = y2; obs_y[3] = y3; obs_y[4] = y4;
    obs_sy[0] = s_y0; obs_sy[1] = s_y1; obs_sy[2] = s_y2; obs_sy[3] = s_y3; obs_sy[4] = s_y4;
    if (chain) begin
      start = 1'b1; has_ad = 1'b0;
      x0 = '0; x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if ({busy, done, ad_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, ad_ready}); end
    n_tests++; if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", blk_cnt); end
    n_tests++; if ((y0 | y1 | y2 | y3 | y4) !== 64'd0) begin n_fail++; $display("FAIL reset_y: got %h expected 0", y0 | y1 | y2 | y3 | y4); end
    n_tests++; if ({s_busy, s_done, s_ready, s_cnt} !== 5'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", {s_busy, s_done, s_ready, s_cnt}); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_ad();
    for (int k = 0; k < 5; k++) x_in[k] = '0;
    do_run(1'b0, 0, 0, 0, 1'b0, 1'b0);
    n_tests++; if (obs_timeout) begin n_fail++; $display("FAIL no_ad_timeout: got timeout expected done"); end
    n_tests++; if (obs_lat != 2) begin n_fail++; $display("FAIL no_ad_latency: got %0d expected 2", obs_lat); end
    n_tests++; if ((obs_y[0] | obs_y[1] | obs_y[2] | obs_y[3]) !== 64'd0) begin n_fail++; $display("FAIL no_ad_y0_3: got %h expected 0", obs_y[0] | obs_y[1] | obs_y[2] | obs_y[3]); end
    n_tests++; if (obs_y[4] !== 64'd1) begin n_fail++; $display("FAIL no_ad_y4: got %h expected 1", obs_y[4]); end
    n_tests++; if (obs_cnt != 0) begin n_fail++; $display("FAIL no_ad_cnt: got %0d expected 0", obs_cnt); end
    n_tests++; if (obs_rdy_seen) begin n_fail++; $display("FAIL no_ad_ready: got 1 expected 0"); end
    n_tests++; if (!obs_busy1) begin n_fail++; $display("FAIL no_ad_busy: got 0 expected 1"); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL no_ad_done_width: got %b expected 0", done); end
  endtask

  task automatic test_partial_word();
    x_in[0] = 64'h0123_4567_89ab_cdef; x_in[1] = 64'hfedc_ba98_7654_3210;
    x_in[2] = 64'h0f0f_0f0f_f0f0_f0f0; x_in[3] = 64'h1111_2222_3333_4444;
    x_in[4] = 64'hdead_beef_cafe_f00d;
    ad_w[0] = 64'h4142_43FF_FFFF_FFFF;
    do_run(1'b1, 1, 3, 0, 1'b0, 1'b0);
    ref_run(1'b1, 1, 3);
    n_tests++; if (obs_lat != 3 || obs_timeout) begin n_fail++; $display("FAIL partial_latency: got %0d expected 3", obs_lat); end
    n_tests++; if (obs_cnt != 1) begin n_fail++; $display("FAIL partial_cnt: got %0d expected 1", obs_cnt); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (obs_y[k] !== exp_y[k]) begin n_fail++; $display("FAIL partial_y%0d: got %h expected %h", k, obs_y[k], exp_y[k]); end
    end
    repeat (3) @(negedge clk);
    n_tests++; if (y0 !== exp_y[0] || y4 !== exp_y[4]) begin n_fail++; $display("FAIL partial_y_hold: got %h expected %h", y0, exp_y[0]); end
    n_tests++; if (blk_cnt !== 16'd1) begin n_fail++; $display("FAIL partial_cnt_hold: got %0d expected 1", blk_cnt); end
  endtask

  task automatic test_full_word_pad();
    x_in[0] = 64'h0000_0000_0000_0080; x_in[1] = 64'h5555_aaaa_5555_aaaa;
    x_in[2] = 64'h0; x_in[3] = 64'hffff_ffff_ffff_ffff; x_in[4] = 64'h1234_0000_0000_5678;
    ad_w[0] = 64'h6869_6a6b_6c6d_6e6f;
    ref_run(1'b1, 1, 8);
    for (int lb = 8; lb <= 12; lb += 4) begin
      do_run(1'b1, 1, lb, 0, 1'b0, 1'b0);
      n_tests++; if (obs_lat != 4 || obs_timeout) begin n_fail++; $display("FAIL pad_latency_b%0d: got %0d expected 4", lb, obs_lat); end
      n_tests++; if (obs_cnt != 2) begin n_fail++; $display("FAIL pad_cnt_b%0d: got %0d expected 2", lb, obs_cnt); end
      n_tests++; if (obs_pad_rdy) begin n_fail++; $display("FAIL pad_ready_b%0d: got 1 expected 0", lb); end
      for (int k = 0; k < 5; k++) begin
        n_tests++; if (obs_y[k] !== exp_y[k]) begin n_fail++; $display("FAIL pad_y%0d_b%0d: got %h expected %h", k, lb, obs_y[k], exp_y[k]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] ref_y [5];
    x_in[0] = 64'h8040_0c06_0000_0000; x_in[1] = 64'h0; x_in[2] = 64'h0123_0123_0123_0123;
    x_in[3] = 64'hbeef_0000_beef_0000; x_in[4] = 64'h7;
    ad_w[0] = 64'h0001_0203_0405_0607; ad_w[1] = 64'h0809_0a0b_0c0d_0e0f;
    ad_w[2] = 64'hf0e1_d2c3_b4a5_9687; ad_w[3] = 64'hffff_ffff_ffff_ffff;
    ref_run(1'b1, 4, 0);
    do_run(1'b1, 4, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) ref_y[k] = obs_y[k];
    n_tests++; if (obs_lat != 6 || obs_timeout) begin n_fail++; $display("FAIL stall_nogap_latency: got %0d expected 6", obs_lat); end
    do_run(1'b1, 4, 0, 2, 1'b0, 1'b0);
    n_tests++; if (obs_lat != 14 || obs_timeout) begin n_fail++; $display("FAIL stall_latency: got %0d expected 14", obs_lat); end
    n_tests++; if (obs_cnt != 4) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 4", obs_cnt); end
    n_tests++; if (obs_cnt2 !== 2'd3) begin n_fail++; $display("FAIL stall_cnt_sat: got %0d expected 3", obs_cnt2); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (obs_y[k] !== exp_y[k] || ref_y[k] !== exp_y[k]) begin n_fail++; $display("FAIL stall_y%0d: got %h / %h expected %h", k, obs_y[k], ref_y[k], exp_y[k]); end
      n_tests++; if (obs_sy[k] !== exp_y[k]) begin n_fail++; $display("FAIL stall_sat_y%0d: got %h expected %h", k, obs_sy[k], exp_y[k]); end
    end
  endtask

  task automatic test_reset_mid_absorb();
    bit done_seen;
    @(negedge clk);
    start = 1'b1; has_ad = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ad_valid = 1'b1; ad_data = 64'h1122_3344_5566_7788; ad_last = 1'b0;
    @(negedge clk);
    ad_valid = 1'b0;
    n_tests++; if (blk_cnt !== 16'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got cnt %0d busy %b expected 1 1", blk_cnt, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({busy, ad_ready, done} !== 3'b000) begin n_fail++; $display("FAIL rst_async_ctrl: got %b expected 000", {busy, ad_ready, done}); end
    n_tests++; if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d expected 0", blk_cnt); end
    n_tests++; if ((y0 | y1 | y2 | y3 | y4) !== 64'd0) begin n_fail++; $display("FAIL rst_async_y: got %h expected 0", y0 | y1 | y2 | y3 | y4); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      done_seen = done_seen | done | busy;
    end
    n_tests++; if (done_seen) begin n_fail++; $display("FAIL rst_no_done: got activity expected none"); end
    x_in[0] = 64'h0; x_in[1] = 64'h1; x_in[2] = 64'h2; x_in[3] = 64'h3; x_in[4] = 64'h4;
    ad_w[0] = 64'h7a00_0000_0000_0000;
    do_run(1'b1, 1, 1, 0, 1'b0, 1'b0);
    ref_run(1'b1, 1, 1);
    n_tests++; if (obs_cnt != 1 || obs_lat != 3) begin n_fail++; $display("FAIL rst_rerun: got cnt %0d lat %0d expected 1 3", obs_cnt, obs_lat); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (obs_y[k] !== exp_y[k]) begin n_fail++; $display("FAIL rst_rerun_y%0d: got %h expected %h", k, obs_y[k], exp_y[k]); end
    end
  endtask

  task automatic test_start_while_busy();
    x_in[0] = 64'hcafe_babe_0000_0001; x_in[1] = 64'h0000_ffff_0000_ffff;
    x_in[2] = 64'h9999_8888_7777_6666; x_in[3] = 64'h0; x_in[4] = 64'h0102_0304_0506_0708;
    ad_w[0] = 64'h5a5a_5a5a_a5a5_a5a5; ad_w[1] = 64'h0102_0304_0506_0708;
    do_run(1'b1, 2, 5, 0, 1'b1, 1'b0);
    ref_run(1'b1, 2, 5);
    n_tests++; if (obs_cnt != 2 || obs_lat != 4 || obs_timeout) begin n_fail++; $display("FAIL busy_start_run: got cnt %0d lat %0d expected 2 4", obs_cnt, obs_lat); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (obs_y[k] !== exp_y[k]) begin n_fail++; $display("FAIL busy_start_y%0d: got %h expected %h", k, obs_y[k], exp_y[k]); end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    x_in[0] = 64'h3; x_in[1] = 64'h5; x_in[2] = 64'h7; x_in[3] = 64'h9; x_in[4] = 64'hb;
    ad_w[0] = 64'h0000_0000_0000_0001;
    do_run(1'b1, 1, 8, 0, 1'b0, 1'b1);
    n_tests++; if (obs_cnt != 2) begin n_fail++; $display("FAIL b2b_first_cnt: got %0d expected 2", obs_cnt); end
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (blk_cnt !== 16'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got cnt %0d busy %b expected 0 1", blk_cnt, busy); end
    @(negedge clk);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
    n_tests++; if (y0 !== 64'd0 || y4 !== 64'd1) begin n_fail++; $display("FAIL b2b_y: got %h %h expected 0 1", y0, y4); end
  endtask

  initial begin
    ad_w[0] = '0;
    test_reset();
    test_no_ad();
    test_partial_word();
    test_full_word_pad();
    test_stall();
    test_reset_mid_absorb();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
